// File: rtl/imem_boot_loader.sv
// Boot loader: streams a program into instruction memory, verifies a 16-bit
// additive checksum, then releases the pipelined CPU with a one-cycle start pulse.
module imem_boot_loader #(
  parameter int ADDR_W     = 9,
  parameter int DATA_W     = 16,
  parameter int START_ADDR = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              enable,
  input  logic              load_req,
  input  logic [ADDR_W-1:0] load_len,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic              i_we,
  output logic [ADDR_W-1:0] i_addr,
  output logic [DATA_W-1:0] i_dataout,
  output logic              cpu_start,
  output logic              cpu_enable,
  output logic              busy,
  output logic              cksum_err
);

  typedef enum logic [2:0] {IDLE, LOAD, CKSUM, LAUNCH, RUN} state_t;

  state_t            state;
  state_t            state_nxt;
  logic [ADDR_W-1:0] len;
  logic [ADDR_W-1:0] count;
  logic [ADDR_W-1:0] count_inc;
  logic [15:0]       sum;
  logic [15:0]       word16;
  logic              we_q;
  logic              xfer;

  assign xfer      = in_valid && in_ready;
  assign count_inc = count + ADDR_W'(1);
  assign word16    = 16'(in_data);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (enable) begin
      unique case (state)
        IDLE, RUN: if (load_req) state_nxt = (load_len == '0) ? CKSUM : LOAD;
        LOAD:      if (xfer && (count_inc == len)) state_nxt = CKSUM;
        CKSUM:     if (xfer) state_nxt = (word16 == sum) ? LAUNCH : IDLE;
        LAUNCH:    state_nxt = RUN;
        default:   state_nxt = IDLE;
      endcase
    end
  end

  // Write strobe is held pending while disabled so a stalled write is delayed, not lost.
  always_comb begin
    in_ready   = enable && ((state == LOAD) || (state == CKSUM));
    cpu_start  = enable && (state == LAUNCH);
    cpu_enable = (state == RUN);
    busy       = (state == LOAD) || (state == CKSUM) || (state == LAUNCH);
    i_we       = we_q && enable;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      len       <= '0;
      count     <= '0;
      sum       <= '0;
      cksum_err <= 1'b0;
      we_q      <= 1'b0;
      i_addr    <= '0;
      i_dataout <= '0;
    end else if (enable) begin
      we_q <= 1'b0;
      unique case (state)
        IDLE, RUN: begin
          if (load_req) begin
            len       <= load_len;
            count     <= '0;
            sum       <= '0;
            cksum_err <= 1'b0;
          end
        end
        LOAD: begin
          if (xfer) begin
            we_q      <= 1'b1;
            i_addr    <= ADDR_W'(START_ADDR) + count;
            i_dataout <= in_data;
            sum       <= sum + word16;
            count     <= count_inc;
          end
        end
        CKSUM: begin
          if (xfer && (word16 != sum)) cksum_err <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/imem_boot_loader.md
IMEM_BOOT_LOADER -- requirements
Module: imem_boot_loader

Interface
REQ-001 SHALL have parameter ADDR_W, default 9, instruction-memory address width.
REQ-002 SHALL have parameter DATA_W, default 16, instruction word width.
REQ-003 SHALL have parameter START_ADDR, default 0, first instruction-memory address written.
REQ-004 SHALL have port clk  input  1  sole clock; all state changes on its rising edge.
REQ-005 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port enable  input  1  global enable; low freezes all state.
REQ-007 SHALL have port load_req  input  1  request to begin a program download.
REQ-008 SHALL have port load_len  input  ADDR_W  number of program words, sampled with load_req.
REQ-009 SHALL have port in_valid  input  1  upstream word valid.
REQ-010 SHALL have port in_data  input  DATA_W  upstream word.
REQ-011 SHALL have port in_ready  output  1  loader can accept a word.
REQ-012 SHALL have port i_we  output  1  instruction-memory write strobe.
REQ-013 SHALL have port i_addr  output  ADDR_W  instruction-memory write address.
REQ-014 SHALL have port i_dataout  output  DATA_W  instruction-memory write data.
REQ-015 SHALL have port cpu_start  output  1  one-cycle start pulse to the pipelined CPU.
REQ-016 SHALL have port cpu_enable  output  1  CPU enable; high only after a verified load.
REQ-017 SHALL have port busy  output  1  high in LOAD, CKSUM, LAUNCH.
REQ-018 SHALL have port cksum_err  output  1  sticky checksum-mismatch flag.

Function
REQ-019 SHALL implement states IDLE, LOAD, CKSUM, LAUNCH, RUN.
REQ-020 SHALL, in IDLE or RUN with load_req=1, latch load_len, clear word counter, 16-bit running sum and cksum_err, drop cpu_enable, go to LOAD (or CKSUM if load_len=0).
REQ-021 SHALL ignore load_req in LOAD, CKSUM, LAUNCH.
REQ-022 SHALL drive in_ready=1 only in LOAD or CKSUM with enable=1; a transfer is in_valid&&in_ready on a rising edge.
REQ-023 SHALL, per LOAD transfer, on the next cycle pulse i_we=1 for one cycle with i_addr=(START_ADDR+count) mod 2^ADDR_W and i_dataout=word.
REQ-024 SHALL add each LOAD word to the running sum modulo 2^16 and increment count; after the load_len-th transfer go to CKSUM.
REQ-025 SHALL treat the single CKSUM transfer as the checksum word and never write it to memory.
REQ-026 SHALL, if checksum word equals running sum, go to LAUNCH; else set cksum_err=1 and return to IDLE.
REQ-027 SHALL assert cpu_start for exactly the one LAUNCH cycle, then enter RUN.
REQ-028 SHALL hold cpu_enable=1 throughout RUN and 0 in every other state.
REQ-029 SHALL, with enable=0, hold state, counters and sum, drive in_ready=0, i_we=0, cpu_start=0; a LAUNCH cycle is deferred, not lost.
REQ-030 SHALL tolerate arbitrary in_valid gaps; no word dropped or duplicated.
REQ-031 SHALL keep i_we=0 outside the cycle following a LOAD transfer.

Reset
REQ-032 SHALL, on rst_n=0 at any time including mid-load, immediately force state IDLE, count=0, sum=0, and all outputs (in_ready, i_we, i_addr, i_dataout, cpu_start, cpu_enable, busy, cksum_err) to 0.
REQ-033 SHALL NOT clear instruction-memory contents already written before reset.
REQ-034 SHALL require a fresh load_req after reset release before any write or start.

Verification
REQ-035 SHALL verify: load_len=3, words 0x1001,0x2002,0x3003, checksum 0x6006 -> writes at 0,1,2, one cpu_start pulse, cpu_enable=1, cksum_err=0.
REQ-036 SHALL verify: same words, checksum 0x6007 -> three writes, no cpu_start, cksum_err=1, state IDLE, cpu_enable=0.
REQ-037 SHALL verify: load_len=0, checksum 0x0000 -> no i_we, cpu_start pulses; checksum 0x0001 -> cksum_err=1.
REQ-038 SHALL verify: START_ADDR=510, load_len=4 -> i_addr sequence 510,511,0,1.
REQ-039 SHALL verify: random in_valid gaps plus enable low for 5 cycles mid-load -> identical memory image, exactly one i_we per word.
REQ-040 SHALL verify: rst_n low after 2 of 5 words -> all outputs 0 immediately, words 0-1 retained, no cpu_start until new load_req completes.
